lcd_pattern_gen: RTL
====================

// Module: lcd_pattern_gen
// PURPOSE
//  Parametrised RGB-parallel LCD timing and test-pattern generator; successor to the fixed 1-bit tester.
//  Generates HS/VS/DE for any panel timing, with COLOR_W bits per channel and 6 run-time selectable patterns.
//  Sits directly behind the pixel clock pin in the top level; outputs drive the LCD pads without further logic.
// PARAMETERS
//  H_ACTIVE  480  visible pixels per line
//  H_FP      8    horizontal front porch (clocks)
//  H_SYNC    4    HS pulse width (clocks)
//  H_BP      43   horizontal back porch (clocks)
//  V_ACTIVE  272  visible lines per frame
//  V_FP      8    vertical front porch (lines)
//  V_SYNC    4    VS pulse width (lines)
//  V_BP      12   vertical back porch (lines)
//  COLOR_W   8    bits per colour channel (1..8)
//  HS_POL    0    HS active level (0 = active-low)
//  VS_POL    0    VS active level (0 = active-low)
//  CHK_LOG2  4    checkerboard square size = 2**CHK_LOG2 pixels
// PORTS
//  i_clk        in   1        pixel clock
//  i_reset_n    in   1        asynchronous active-low reset
//  i_mode       in   3        pattern select; sampled at frame boundary only
//  o_lcd_hs     out  1        horizontal sync
//  o_lcd_vs     out  1        vertical sync
//  o_lcd_de     out  1        data enable, high for visible pixels
//  o_lcd_r/g/b  out  COLOR_W  pixel colour, each channel
//  o_frame_sof  out  1        1-clock pulse aligned with first visible pixel of each frame
//  o_frame_cnt  out  16       completed-frame counter, wraps 0xFFFF->0
// BEHAVIOUR
//  - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. h_cnt 0..H_TOTAL-1; v_cnt advances when h_cnt wraps.
//  - Line/frame order: active, front porch, sync, back porch. HS asserted for h_cnt in [H_ACTIVE+H_FP, +H_SYNC); VS same on v_cnt.
//  - DE = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE). All outputs registered: output at edge n+1 reflects counters at edge n; HS/VS/DE/RGB/SOF mutually aligned.
//  - Reset (async assert, sync release): counters 0, HS=~HS_POL, VS=~VS_POL, DE=0, RGB=0, SOF=0, frame_cnt=0, mode latch=0, bar_pos=0.
//  - First active pixel appears 1 clock after first clock edge following reset release, with SOF=1.
//  - Mode latch: i_mode captured only on last clock of frame (h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1); mid-frame changes ignored. Same edge: frame_cnt+1, bar_pos advance.
//  - RGB forced to 0 whenever DE=0. Full-scale = all ones in COLOR_W bits.
//  - Mode 0 colour bars: 8 bars of BAR_W=H_ACTIVE/8 pixels: white,yellow,cyan,green,magenta,red,blue,black; remainder pixels black. No divider: bar index from a BAR_W run counter.
//  - Mode 1 grey ramp: R=G=B=h_cnt[COLOR_W-1:0] (wraps every 2**COLOR_W pixels).
//  - Mode 2 checkerboard: white when h_cnt[CHK_LOG2]^v_cnt[CHK_LOG2]==0, else black.
//  - Mode 3 moving bar: white for h_cnt in [bar_pos, bar_pos+16) (no wrap of bar), else blue; bar_pos +1 per frame, wraps H_ACTIVE-1 -> 0.
//  - Mode 4 solid white; mode 5 solid red/green/blue cycling per frame (frame_cnt mod 3: 0=R,1=G,2=B).
//  - Modes 6,7 reserved: output black with correct timing.
//  - Counter widths: ceil(log2(H_TOTAL)) and ceil(log2(V_TOTAL)); no overflow beyond TOTAL-1.
//  - Reset mid-frame: all state cleared immediately; next frame starts cleanly from h=v=0.
// CONFIGURATION
//  LCD_BORDER_EN defined: 1-pixel white border overlaid on all modes (h_cnt==0, H_ACTIVE-1; v_cnt==0, V_ACTIVE-1), incl. reserved modes.
//  LCD_BORDER_EN undefined: no overlay; pattern pixels unmodified; border logic absent from netlist.
// TESTING (default parameters, H_TOTAL=535, V_TOTAL=296)
//  1 Reset held, clocks running -> HS=1,VS=1,DE=0,RGB=0,frame_cnt=0; release -> DE rises 1 clk later with SOF=1.
//  2 Free-run 3 frames -> HS low 4 clks every 535; VS low 4 lines every 296; DE high 480 clks x 272 lines/frame; frame_cnt=3.
//  3 Mode 0 -> pixel 0 RGB=FF/FF/FF, pixel 60 FF/FF/00, pixel 420 00/00/00; mode 1 -> pixel 300 RGB=2C/2C/2C.
//  4 Change i_mode 0->2 mid-frame -> current frame stays bars; next frame pixel (16,0)=black, (16,16)=white.
//  5 Mode 3 for 2 frames -> bar starts x=0 frame 0, x=1 frame 1; bar_pos=479 wraps to 0 next frame.
//  6 Assert i_reset_n low at h=200,v=100 -> outputs reset asynchronously; release -> timing restarts at h=v=0, SOF pulse.
//  7 With LCD_BORDER_EN, mode 6 -> pixel (0,5) and (479,5) white, (1,5) black; without it all black.

Source files
------------

// File: rtl/lcd_pattern_gen.sv
// RGB-parallel LCD timing generator with six run-time selectable test patterns.
// Optional build macro LCD_BORDER_EN overlays a 1-pixel white border on every mode.
module lcd_pattern_gen #(
  parameter int unsigned H_ACTIVE = 480,
  parameter int unsigned H_FP     = 8,
  parameter int unsigned H_SYNC   = 4,
  parameter int unsigned H_BP     = 43,
  parameter int unsigned V_ACTIVE = 272,
  parameter int unsigned V_FP     = 8,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 12,
  parameter int unsigned COLOR_W  = 8,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CHK_LOG2 = 4
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [2:0]         i_mode,
  output logic               o_lcd_hs,
  output logic               o_lcd_vs,
  output logic               o_lcd_de,
  output logic [COLOR_W-1:0] o_lcd_r,
  output logic [COLOR_W-1:0] o_lcd_g,
  output logic [COLOR_W-1:0] o_lcd_b,
  output logic               o_frame_sof,
  output logic [15:0]        o_frame_cnt
);

  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_W       = $clog2(H_TOTAL);
  localparam int unsigned V_W       = $clog2(V_TOTAL);
  localparam int unsigned HX_W      = H_W + 1;
  localparam int unsigned VX_W      = V_W + 1;
  localparam int unsigned BAR_W     = H_ACTIVE / 8;
  localparam int unsigned BAR_RUN_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int unsigned BAR_LEN   = 16;

  logic [H_W-1:0]       h_cnt;
  logic [V_W-1:0]       v_cnt;
  logic [BAR_RUN_W-1:0] bar_run;
  logic [3:0]           bar_idx;
  logic [2:0]           mode_q;
  logic [H_W-1:0]       bar_pos;
  logic [1:0]           rgb_sel;

  logic               h_last_c;
  logic               v_last_c;
  logic               frame_end_c;
  logic               de_c;
  logic               hs_c;
  logic               vs_c;
  logic               sof_c;
  logic               in_bar_c;
  logic [HX_W-1:0]    h_ext_c;
  logic [VX_W-1:0]    v_ext_c;
  logic [HX_W-1:0]    bar_end_c;
  logic [2:0]         bar_rgb_c;
  logic [2:0]         prim_c;
  logic               grey_c;
  logic [COLOR_W-1:0] r_c;
  logic [COLOR_W-1:0] g_c;
  logic [COLOR_W-1:0] b_c;

  assign h_last_c    = (h_cnt == H_W'(H_TOTAL - 1));
  assign v_last_c    = (v_cnt == V_W'(V_TOTAL - 1));
  assign frame_end_c = h_last_c && v_last_c;

  // Extended copies keep sync-window compares safe when a window ends at 2**W.
  assign h_ext_c = HX_W'(h_cnt);
  assign v_ext_c = VX_W'(v_cnt);

  assign de_c  = (h_cnt < H_W'(H_ACTIVE)) && (v_cnt < V_W'(V_ACTIVE));
  assign hs_c  = (h_ext_c >= HX_W'(H_ACTIVE + H_FP)) &&
                 (h_ext_c <  HX_W'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_c  = (v_ext_c >= VX_W'(V_ACTIVE + V_FP)) &&
                 (v_ext_c <  VX_W'(V_ACTIVE + V_FP + V_SYNC));
  assign sof_c = (h_cnt == '0) && (v_cnt == '0);

  // Bar order white,yellow,cyan,green,magenta,red,blue,black maps onto idx bits; idx 8 = remainder.
  assign bar_rgb_c = {~bar_idx[1], ~bar_idx[2], ~bar_idx[0]} & {3{~bar_idx[3]}};

  // Moving bar stops at its right edge instead of wrapping to the line start.
  assign bar_end_c = HX_W'(bar_pos) + HX_W'(BAR_LEN);
  assign in_bar_c  = (h_cnt >= bar_pos) && (h_ext_c < bar_end_c);

`ifdef LCD_BORDER_EN
  logic border_c;
  assign border_c = (h_cnt == '0) || (h_cnt == H_W'(H_ACTIVE - 1)) ||
                    (v_cnt == '0) || (v_cnt == V_W'(V_ACTIVE - 1));
`endif

  // Pattern pixel for the current counter position; blanked outside the active area.
  always_comb begin
    prim_c = 3'b000;
    grey_c = 1'b0;
    if (de_c) begin
      case (mode_q)
        3'd0:    prim_c = bar_rgb_c;
        3'd1:    grey_c = 1'b1;
        3'd2:    prim_c = (h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2]) ? 3'b000 : 3'b111;
        3'd3:    prim_c = in_bar_c ? 3'b111 : 3'b001;
        3'd4:    prim_c = 3'b111;
        3'd5:    prim_c = 3'b100 >> rgb_sel;
        default: prim_c = 3'b000;
      endcase
`ifdef LCD_BORDER_EN
      if (border_c) begin
        prim_c = 3'b111;
        grey_c = 1'b0;
      end
`endif
    end
    r_c = grey_c ? h_cnt[COLOR_W-1:0] : {COLOR_W{prim_c[2]}};
    g_c = grey_c ? h_cnt[COLOR_W-1:0] : {COLOR_W{prim_c[1]}};
    b_c = grey_c ? h_cnt[COLOR_W-1:0] : {COLOR_W{prim_c[0]}};
  end

  // Raster counters plus per-frame state that only moves on the last clock of a frame.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      bar_run     <= '0;
      bar_idx     <= '0;
      mode_q      <= '0;
      bar_pos     <= '0;
      rgb_sel     <= '0;
      o_frame_cnt <= '0;
    end else begin
      if (h_last_c) begin
        h_cnt <= '0;
        v_cnt <= v_last_c ? '0 : v_cnt + V_W'(1);
      end else begin
        h_cnt <= h_cnt + H_W'(1);
      end

      // Run counter tracks h_cnt so the bar index needs no divider.
      if (h_last_c) begin
        bar_run <= '0;
        bar_idx <= '0;
      end else if (!bar_idx[3]) begin
        if (bar_run == BAR_RUN_W'(BAR_W - 1)) begin
          bar_run <= '0;
          bar_idx <= bar_idx + 4'd1;
        end else begin
          bar_run <= bar_run + BAR_RUN_W'(1);
        end
      end

      if (frame_end_c) begin
        mode_q      <= i_mode;
        o_frame_cnt <= o_frame_cnt + 16'd1;
        bar_pos     <= (bar_pos == H_W'(H_ACTIVE - 1)) ? '0 : bar_pos + H_W'(1);
        // 0xFFFF is a multiple of 3, so the wrap to 0 must also restart the colour cycle.
        if (o_frame_cnt == 16'hFFFF) begin
          rgb_sel <= '0;
        end else begin
          rgb_sel <= (rgb_sel == 2'd2) ? 2'd0 : rgb_sel + 2'd1;
        end
      end
    end
  end

  // Registered pad outputs, all reflecting the same counter snapshot.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_lcd_hs    <= ~HS_POL;
      o_lcd_vs    <= ~VS_POL;
      o_lcd_de    <= 1'b0;
      o_lcd_r     <= '0;
      o_lcd_g     <= '0;
      o_lcd_b     <= '0;
      o_frame_sof <= 1'b0;
    end else begin
      o_lcd_hs    <= hs_c ? HS_POL : ~HS_POL;
      o_lcd_vs    <= vs_c ? VS_POL : ~VS_POL;
      o_lcd_de    <= de_c;
      o_lcd_r     <= r_c;
      o_lcd_g     <= g_c;
      o_lcd_b     <= b_c;
      o_frame_sof <= sof_c;
    end
  end

endmodule
